// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: state encoding, default
// sizing constants and a sign-extension helper used by the accumulator.
package mac_pkg;

  // Default sizing; the sequencer parameters fall back to these.
  localparam int DEFAULT_WIDTH     = 4;
  localparam int DEFAULT_ACC_WIDTH = 12;
  localparam int DEFAULT_LEN_WIDTH = 4;
  localparam int DEFAULT_TIMEOUT   = 16;

  // Widest value the sign-extension helper can handle.
  localparam int EXT_MAX = 64;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Replicates bit (from_width-1) of value into every higher bit.
  // Built from masks rather than a variable bit-select so it stays
  // width-clean for any from_width in 1..EXT_MAX.
  function automatic logic [EXT_MAX-1:0] sign_extend(
    input logic [EXT_MAX-1:0] value,
    input int                 from_width
  );
    logic [EXT_MAX-1:0] sign_bit;
    logic [EXT_MAX-1:0] upper;
    sign_bit = value & ({{(EXT_MAX-1){1'b0}}, 1'b1} << (from_width - 1));
    upper    = {EXT_MAX{1'b1}} << from_width;
    return (sign_bit != '0) ? (value | upper) : (value & ~upper);
  endfunction

endpackage

// File: rtl/mac_accumulator.sv
// Signed accumulator for the MAC sequencer. Sign-extends each product to
// the accumulator width, adds with two's-complement wrap, and keeps a
// sticky signed-overflow flag. Synchronous clear has priority over enable.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_WIDTH = 2 * DEFAULT_WIDTH,
  parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PROD_WIDTH-1:0] product,
  output logic [ACC_WIDTH-1:0]  acc,
  output logic                  overflow
);

  logic [ACC_WIDTH-1:0] acc_reg;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 overflow_reg;
  logic [ACC_WIDTH-1:0] product_ext;
  logic                 add_overflow;

  // Product widened to the accumulator width, sign preserved.
  assign product_ext = ACC_WIDTH'(sign_extend(EXT_MAX'(product), PROD_WIDTH));

  // Wrapping sum; overflow when both addends share a sign the result lacks.
  always_comb begin
    acc_next     = acc_reg + product_ext;
    add_overflow = (acc_reg[ACC_WIDTH-1] == product_ext[ACC_WIDTH-1]) &&
                   (acc_next[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]);
  end

  // Accumulator and sticky overflow registers.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      acc_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (clr) begin
      acc_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (en) begin
      acc_reg      <= acc_next;
      overflow_reg <= overflow_reg | add_overflow;
    end
  end

  assign acc      = acc_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: pulls operand pairs from a valid/ready stream,
// drives one shared Booth multiplier per pair, accumulates the products
// and presents the signed sum on a valid/ready result port. A watchdog
// aborts a term whose multiplier never reports done.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int ACC_WIDTH = DEFAULT_ACC_WIDTH,   // must be >= 2*WIDTH
  parameter int LEN_WIDTH = DEFAULT_LEN_WIDTH,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                   clock,
  input  logic                   clear_n,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_a,
  input  logic [WIDTH-1:0]       in_b,
  output logic                   mul_load,
  output logic                   mul_clear,
  output logic [WIDTH-1:0]       mul_multiplicand,
  output logic [WIDTH-1:0]       mul_multiplier,
  input  logic [2*WIDTH-1:0]     mul_product,
  input  logic                   mul_done,
  output logic [ACC_WIDTH-1:0]   acc_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   overflow,
  output logic                   error
);

  localparam int WD_WIDTH = $clog2(TIMEOUT + 1);

  state_t               state_reg;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] len_reg;
  logic [LEN_WIDTH-1:0] count_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WD_WIDTH-1:0]  wd_reg;
  logic                 error_reg;

  logic                 job_start;
  logic                 done_accept;
  logic                 timeout_hit;
  logic                 term_last;
  logic                 acc_clr;
  logic                 acc_en;

  // Decoded conditions shared by next-state, output and datapath logic.
  // done is masked while wd_reg is 0 (first WAIT cycle) because the
  // multiplier may still be showing done from the previous term.
  always_comb begin
    job_start   = (state_reg == IDLE) && start;
    done_accept = (state_reg == WAIT) && mul_done && (wd_reg != '0);
    timeout_hit = (state_reg == WAIT) && !done_accept &&
                  (wd_reg == WD_WIDTH'(TIMEOUT - 1));
    term_last   = ((count_reg + LEN_WIDTH'(1)) == len_reg);
    acc_clr     = job_start;
    acc_en      = (state_reg == ACCUM);
  end

  // State register.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (done_accept) begin
          state_next = ACCUM;
        end else if (timeout_hit) begin
          state_next = DONE;
        end
      end
      ACCUM: begin
        state_next = term_last ? DONE : FETCH;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs, plus the one-cycle multiplier clear on a watchdog abort.
  always_comb begin
    in_ready  = 1'b0;
    mul_load  = 1'b0;
    mul_clear = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        mul_clear = 1'b1;
        busy      = 1'b0;
      end
      FETCH: begin
        in_ready = 1'b1;
      end
      ISSUE: begin
        mul_load = 1'b1;
      end
      WAIT: begin
        mul_clear = timeout_hit;
      end
      DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Job length, term counter, operand holding registers, watchdog and
  // sticky timeout flag. Operands are captured only on the FETCH
  // handshake so they stay put through ISSUE, WAIT and ACCUM.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      len_reg   <= '0;
      count_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      wd_reg    <= '0;
      error_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg   <= len;
            count_reg <= '0;
            error_reg <= 1'b0;
          end
        end
        FETCH: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
          end
        end
        ISSUE: begin
          wd_reg <= '0;
        end
        WAIT: begin
          wd_reg <= wd_reg + WD_WIDTH'(1);
          if (timeout_hit) begin
            error_reg <= 1'b1;
          end
        end
        ACCUM: begin
          count_reg <= count_reg + LEN_WIDTH'(1);
        end
        default: begin
          count_reg <= count_reg;
        end
      endcase
    end
  end

  mac_accumulator #(
    .PROD_WIDTH (2 * WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .clock    (clock),
    .clear_n  (clear_n),
    .clr      (acc_clr),
    .en       (acc_en),
    .product  (mul_product),
    .acc      (acc_out),
    .overflow (overflow)
  );

  assign mul_multiplicand = a_reg;
  assign mul_multiplier   = b_reg;
  assign error            = error_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer with a behavioural multiplier model.
// Jobs are issued by the stimulus process, which pushes the expected sum,
// overflow and error onto a queue; a separate monitor pops and compares at
// every result handshake and checks operands at every multiplier load.
module tb_mac_sequencer;

  localparam int W  = 4;
  localparam int AW = 8;
  localparam int LW = 4;
  localparam int TO = 16;
  localparam int PW = 2 * W;

  typedef struct packed {
    logic [AW-1:0] acc;
    logic          ovf;
    logic          err;
  } exp_t;

  logic          clock = 1'b0;
  logic          clear_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          mul_load;
  logic          mul_clear;
  logic [W-1:0]  mul_multiplicand;
  logic [W-1:0]  mul_multiplier;
  logic [PW-1:0] mul_product;
  logic          mul_done;
  logic [AW-1:0] acc_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;
  logic          overflow;
  logic          error;

  mac_sequencer #(
    .WIDTH     (W),
    .ACC_WIDTH (AW),
    .LEN_WIDTH (LW),
    .TIMEOUT   (TO)
  ) dut (
    .clock            (clock),
    .clear_n          (clear_n),
    .start            (start),
    .len              (len),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .mul_load         (mul_load),
    .mul_clear        (mul_clear),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product),
    .mul_done         (mul_done),
    .acc_out          (acc_out),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy),
    .overflow         (overflow),
    .error            (error)
  );

  always #5 clock = ~clock;

  // ---------------- multiplier model ----------------
  // Takes 2..4 cycles. On load, done keeps its old level for one more
  // cycle (stale done) before dropping, then rises with the new product.
  logic signed [W-1:0] ma = '0;
  logic signed [W-1:0] mb = '0;
  int                  mcnt = 0;
  bit                  stuck_mode = 1'b0;
  logic [PW-1:0]       prod_r = '0;
  logic                done_r = 1'b0;

  assign mul_product = prod_r;
  assign mul_done    = done_r;

  always @(posedge clock) begin
    if (mul_clear) begin
      done_r <= 1'b0;
      mcnt   <= 0;
    end else if (mul_load) begin
      ma   <= mul_multiplicand;
      mb   <= mul_multiplier;
      mcnt <= int'($urandom_range(2, 4));
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !stuck_mode) begin
        done_r <= 1'b1;
        prod_r <= PW'(int'(ma) * int'(mb));
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  exp_t        exp_q[$];
  logic [PW-1:0] pair_q[$];
  int          pass_count = 0;
  int          check_count = 0;
  int          out_count = 0;
  int          load_count = 0;
  int          busy_clear_count = 0;
  int          since_load = 0;
  logic        err_prev = 1'b0;
  exp_t        mon_e;
  logic [PW-1:0] mon_p;
  logic signed [W-1:0] ja[16];
  logic signed [W-1:0] jb[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    check_count++;
    if (act === req) pass_count++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (clear_n) begin
        if (out_valid && out_ready) begin
          out_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("acc_out", 32'(acc_out), 32'(mon_e.acc));
            check("overflow", 32'(overflow), 32'(mon_e.ovf));
            check("error", 32'(error), 32'(mon_e.err));
            $display("result acc=%0d ovf=%0d err=%0d", $signed(acc_out), overflow, error);
          end
        end
        if (mul_load) begin
          load_count++;
          since_load = 0;
          if (pair_q.size() == 0) begin
            check("load_without_pair", 32'd1, 32'd0);
          end else begin
            mon_p = pair_q.pop_front();
            check("operands", 32'({mul_multiplicand, mul_multiplier}), 32'(mon_p));
          end
        end else begin
          since_load++;
        end
        if (busy && mul_clear) busy_clear_count++;
        if (in_ready) check("in_ready_only_fetch", 32'({busy, mul_load, out_valid}), 32'd4);
        if (error && !err_prev) check("timeout_cycles", 32'(since_load), 32'(TO + 1));
        err_prev = error;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic int wrap_acc(input int t);
    int m;
    int r;
    m = 1 << AW;
    r = t % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  task automatic pulse_start(input int n);
    start = 1'b1;
    len   = LW'(n);
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, input int gap);
    bit accepted;
    accepted = 1'b0;
    repeat (gap) begin @(posedge clock); #1; end
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    pair_q.push_back({a, b});
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (in_ready) begin accepted = 1'b1; break; end
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("fetch_handshake", 32'(accepted), 32'd1);
  endtask

  task automatic run_job(input int n, input int gap_min, input int gap_max,
                         input bit stuck, input bit hold_ready);
    exp_t e;
    int   w;
    int   t;
    int   lim;
    int   feeds;
    int   base;
    int   lb;
    bit   st;
    bit   got;
    bit   done_ok;
    lim = 1 << (AW - 1);
    st  = stuck && (n > 0);
    w   = 0;
    e.ovf = 1'b0;
    e.err = st;
    if (st) begin
      feeds = 1;
    end else begin
      feeds = n;
      for (int i = 0; i < n; i++) begin
        t = w + int'(ja[i]) * int'(jb[i]);
        if (t >= lim || t < -lim) e.ovf = 1'b1;
        w = wrap_acc(t);
      end
    end
    e.acc = AW'(w);
    stuck_mode = st;
    out_ready  = !hold_ready;
    base = out_count;
    lb   = load_count;
    busy_clear_count = 0;
    exp_q.push_back(e);
    $display("job len=%0d stuck=%0d hold=%0d expect acc=%0d ovf=%0d", n, st, hold_ready, w, e.ovf);
    pulse_start(n);
    if (n == 0) begin
      @(negedge clock);
      check("len0_out_valid_latency", 32'(out_valid), 32'd1);
    end
    for (int i = 0; i < feeds; i++) begin
      feed(ja[i], jb[i], int'($urandom_range(gap_min, gap_max)));
    end
    if (hold_ready) begin
      got = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge clock);
        if (out_valid) begin got = 1'b1; break; end
      end
      check("out_valid_seen", 32'(got), 32'd1);
      repeat (5) begin
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_acc_out", 32'(acc_out), 32'(e.acc));
        check("hold_error", 32'(error), 32'(e.err));
        @(negedge clock);
      end
      @(posedge clock); #1;
      out_ready = 1'b1;
    end
    done_ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(posedge clock); #1;
      if (out_count == base + 1) begin done_ok = 1'b1; break; end
    end
    check("result_handshake", 32'(done_ok), 32'd1);
    check("mul_load_count", 32'(load_count - lb), 32'(feeds));
    check("busy_mul_clear_pulses", 32'(busy_clear_count), 32'(st ? 1 : 0));
    @(negedge clock);
    check("idle_after_result", 32'({busy, out_valid}), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_quiet"}, 32'({busy, in_ready, mul_load, out_valid, overflow, error}), 32'd0);
    check({tag, "_mul_clear"}, 32'(mul_clear), 32'd1);
    check({tag, "_acc_out"}, 32'(acc_out), 32'd0);
    check({tag, "_operands"}, 32'({mul_multiplicand, mul_multiplier}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    clear_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock); #1;
    clear_n = 1'b1;
    @(posedge clock); #1;

    // single term: 3 * -4 = -12
    ja[0] = 4'sd3; jb[0] = -4'sd4;
    run_job(1, 0, 0, 1'b0, 1'b0);

    // three terms with two-cycle gaps: -12 + 10 + 64 = 62
    ja[0] = 4'sd3;  jb[0] = -4'sd4;
    ja[1] = 4'sd2;  jb[1] = 4'sd5;
    ja[2] = -4'sd8; jb[2] = -4'sd8;
    run_job(3, 2, 2, 1'b0, 1'b0);

    // empty job
    run_job(0, 0, 0, 1'b0, 1'b0);

    // wrap to -128 with overflow, then a clean job clears the flag
    ja[0] = -4'sd8; jb[0] = -4'sd8;
    ja[1] = -4'sd8; jb[1] = -4'sd8;
    run_job(2, 0, 1, 1'b0, 1'b0);
    ja[0] = 4'sd1; jb[0] = 4'sd1;
    run_job(1, 0, 1, 1'b0, 1'b0);

    // multiplier never finishes: watchdog abort, consumer stalls 5 cycles
    ja[0] = 4'sd5; jb[0] = 4'sd3;
    ja[1] = 4'sd1; jb[1] = 4'sd1;
    run_job(2, 0, 0, 1'b1, 1'b1);

    // reset in the WAIT of the second term of a three-term job
    stuck_mode = 1'b0;
    out_ready  = 1'b1;
    base = out_count;
    pulse_start(3);
    feed(4'sd2, 4'sd3, 0);
    feed(4'sd1, 4'sd2, 0);
    @(posedge clock); #1;
    clear_n = 1'b0;
    @(negedge clock);
    check_reset_outputs("mid_job_reset");
    @(posedge clock); #1;
    clear_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
    check("no_result_after_reset", 32'(out_count - base), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);
    ja[0] = 4'sd2; jb[0] = 4'sd3;
    run_job(1, 0, 0, 1'b0, 1'b0);

    // randomized jobs
    for (int j = 0; j < 25; j++) begin
      int n;
      n = (j % 7 == 6) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 6));
      for (int i = 0; i < 16; i++) begin
        ja[i] = W'($urandom_range(0, 15));
        jb[i] = W'($urandom_range(0, 15));
      end
      run_job(n, 0, 3, ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("pairs_drained", 32'(pair_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  // Backstop so a wedged run still terminates.
  initial begin
    #5000000;
    $display("FAIL global_timeout: got no end of sequence, required finish");
    $fatal(1, "simulation time limit");
  end

endmodule
